// File: rtl/util_pkg.sv
// Shared types and constants for the pulse utilities.
// Holds the per-channel FSM state encoding and the edge-detector reset value.
package util_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } pulse_state_t;

  // A high input held through reset must not look like a fresh rising edge.
  localparam logic D_Q_RST = 1'b1;

endpackage

// File: rtl/pulse_shaper_if.sv
// Configuration, event and status bundle for the pulse_shaper block.
// Software/event side is the master; the shaper is the slave.
interface pulse_shaper_if
  import util_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]            en;
    logic [CHANNELS-1:0]            d;
    logic [CHANNELS-1:0][CNT_W-1:0] cfg_delay;
    logic [CHANNELS-1:0][CNT_W-1:0] cfg_width;
    logic [CHANNELS-1:0]            cfg_retrig;
    logic [CHANNELS-1:0]            ovr_clr;
    logic [CHANNELS-1:0]            q;
    logic [CHANNELS-1:0]            busy;
    logic [CHANNELS-1:0]            overrun;
    pulse_state_t [CHANNELS-1:0]    state;

    modport master (
        output en, d, cfg_delay, cfg_width, cfg_retrig, ovr_clr,
        input  q, busy, overrun, state
    );

    modport slave (
        input  en, d, cfg_delay, cfg_width, cfg_retrig, ovr_clr,
        output q, busy, overrun, state
    );
endinterface

// File: rtl/pulse_shaper_ch.sv
// One pulse delay/stretch channel: rising-edge detect, IDLE/DELAY/ACTIVE FSM,
// down-counter with latched width, and a sticky overrun flag.
module pulse_shaper_ch
  import util_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             cfg_retrig,
    input  logic             ovr_clr,
    output logic             q,
    output logic             busy,
    output logic             overrun,
    output pulse_state_t     state
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             d_q;
    logic             trig;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] w_lat;

    pulse_state_t     acc_state;
    logic [CNT_W-1:0] acc_cnt;

    assign trig = d & ~d_q & en;

    // Outcome of accepting a trigger from IDLE or from the last ACTIVE cycle.
    always_comb begin
        acc_state = IDLE;
        acc_cnt   = '0;
        if (cfg_width != '0) begin
            if (cfg_delay == '0) begin
                acc_state = ACTIVE;
                acc_cnt   = cfg_width;
            end else begin
                acc_state = DELAY;
                acc_cnt   = cfg_delay;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q     <= D_Q_RST;
            state   <= IDLE;
            cnt     <= '0;
            w_lat   <= '0;
            q       <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            d_q <= d;
            if (ovr_clr) overrun <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                q     <= 1'b0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (trig) begin
                            state <= acc_state;
                            cnt   <= acc_cnt;
                            w_lat <= cfg_width;
                            q     <= (acc_state == ACTIVE);
                            busy  <= (acc_state != IDLE);
                        end
                    end
                    DELAY: begin
                        if (trig) overrun <= 1'b1;
                        if (cnt == CNT_ONE) begin
                            state <= ACTIVE;
                            cnt   <= w_lat;
                            q     <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    ACTIVE: begin
                        if (cnt == CNT_ONE) begin
                            if (trig) begin
                                state <= acc_state;
                                cnt   <= acc_cnt;
                                w_lat <= cfg_width;
                                q     <= (acc_state == ACTIVE);
                                busy  <= (acc_state != IDLE);
                            end else begin
                                state <= IDLE;
                                q     <= 1'b0;
                                busy  <= 1'b0;
                            end
                        end else if (trig && cfg_retrig && cfg_width != '0) begin
                            cnt <= cfg_width;
                        end else begin
                            // A zero-width retrigger is ignored, like a zero-width trigger in IDLE.
                            if (trig && !cfg_retrig) overrun <= 1'b1;
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        q     <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/pulse_shaper.sv
// Multi-channel programmable pulse delay/stretch engine.
// Pure replication of independent channels; no cross-channel logic.
module pulse_shaper
  import util_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input logic           clk,
    input logic           rst,
    pulse_shaper_if.slave ps
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_shaper_ch #(.CNT_W(CNT_W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (ps.en[i]),
            .d          (ps.d[i]),
            .cfg_delay  (ps.cfg_delay[i]),
            .cfg_width  (ps.cfg_width[i]),
            .cfg_retrig (ps.cfg_retrig[i]),
            .ovr_clr    (ps.ovr_clr[i]),
            .q          (ps.q[i]),
            .busy       (ps.busy[i]),
            .overrun    (ps.overrun[i]),
            .state      (ps.state[i])
        );
    end
endmodule

// File: tb/tb_pulse_shaper.sv
// Self-checking bench for pulse_shaper: window-based reference model feeding an
// expected-output queue, directed scenarios with fixed cycle windows, random sweep.
module tb_pulse_shaper;
    import util_pkg::*;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int EW = 3 * CH;

    logic clk;
    logic rst;

    pulse_shaper_if #(.CHANNELS(CH), .CNT_W(CW)) ps ();

    pulse_shaper #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .ps  (ps)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // reference model: each channel tracks one pulse window [p_start, p_end]
    int   t = 0;
    bit   have  [CH];
    int   p_start[CH];
    int   p_end  [CH];
    logic m_ovr  [CH];
    logic m_dprev[CH];

    // directed-scenario history of channel 0, indexed by relative cycle
    int          rel = 0;
    logic [63:0] hist_q, hist_b, hist_o;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_step(output logic [EW-1:0] e);
        logic [CH-1:0] eq, eb, eo;
        int dl, wd;
        logic trig, drop;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                have[c]    = 1'b0;
                m_ovr[c]   = 1'b0;
                m_dprev[c] = 1'b1;
            end else begin
                dl   = int'(ps.cfg_delay[c]);
                wd   = int'(ps.cfg_width[c]);
                trig = ps.d[c] & ~m_dprev[c] & ps.en[c];
                drop = 1'b0;
                m_dprev[c] = ps.d[c];
                if (!ps.en[c]) begin
                    have[c] = 1'b0;
                end else if (trig) begin
                    if (!have[c] || t >= p_end[c]) begin
                        if (wd == 0) have[c] = 1'b0;
                        else begin
                            have[c]    = 1'b1;
                            p_start[c] = t + 1 + dl;
                            p_end[c]   = t + dl + wd;
                        end
                    end else if (t < p_start[c]) begin
                        drop = 1'b1;
                    end else if (ps.cfg_retrig[c]) begin
                        if (wd != 0) p_end[c] = t + wd;
                    end else begin
                        drop = 1'b1;
                    end
                end
                m_ovr[c] = (m_ovr[c] & ~ps.ovr_clr[c]) | drop;
            end
            eq[c] = have[c] && (p_start[c] <= t + 1) && (t + 1 <= p_end[c]);
            eb[c] = have[c] && (t + 1 <= p_end[c]);
            eo[c] = m_ovr[c];
        end
        e = {eq, eb, eo};
    endtask

    // driver: apply current inputs for one cycle, then compare the resulting outputs
    task automatic tick();
        logic [EW-1:0] e, got, want;
        model_step(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        t++;
        got  = {ps.q, ps.busy, ps.overrun};
        want = exp_q.pop_front();
        check_val("sb_outputs", 32'(got), 32'(want));
        rel++;
        if (rel < 64) begin
            hist_q[rel] = ps.q[0];
            hist_b[rel] = ps.busy[0];
            hist_o[rel] = ps.overrun[0];
        end
    endtask

    task automatic run_to(input int r);
        while (rel < r) tick();
    endtask

    task automatic start_hist();
        rel    = 0;
        hist_q = '0;
        hist_b = '0;
        hist_o = '0;
    endtask

    task automatic set_cfg(input int c, input int dl, input int wd, input logic rt);
        ps.cfg_delay[c]  = CW'(dl);
        ps.cfg_width[c]  = CW'(wd);
        ps.cfg_retrig[c] = rt;
    endtask

    task automatic clear_ovr();
        ps.ovr_clr = '1;
        tick();
        ps.ovr_clr = '0;
        tick();
    endtask

    // single-cycle trigger on channel 0 at the current relative cycle
    task automatic fire0();
        ps.d[0] = 1'b1;
        tick();
        ps.d[0] = 1'b0;
    endtask

    int vals[5] = '{0, 1, 2, 15, 255};

    initial begin
        rst = 1'b1;
        ps.en = '1;
        ps.d = '1;
        ps.ovr_clr = '0;
        for (int c = 0; c < CH; c++) set_cfg(c, 0, 1, 1'b0);

        // reset with d held high: no trigger after release
        repeat (3) tick();
        check_val("rst_q", 32'(ps.q), 32'h0);
        check_val("rst_busy", 32'(ps.busy), 32'h0);
        check_val("rst_ovr", 32'(ps.overrun), 32'h0);
        check_val("rst_state", 32'(ps.state[0]), 32'(IDLE));
        rst = 1'b0;
        start_hist();
        run_to(5);
        ps.d = '0;
        run_to(12);
        check_val("d_high_thru_rst", hist_q[31:0], 32'h0);

        // basic delay D=3 W=2
        set_cfg(0, 3, 2, 1'b0);
        start_hist(); fire0(); run_to(12);
        check_val("basic_q", hist_q[31:0], 32'h30);
        check_val("basic_busy", hist_b[31:0], 32'h3E);
        check_val("basic_ovr", hist_o[31:0], 32'h0);

        // passthrough D=0 W=1, then W=0
        set_cfg(0, 0, 1, 1'b0);
        start_hist();
        for (int i = 0; i < 8; i++) begin
            ps.d[0] = (i % 2 == 0);
            tick();
        end
        ps.d[0] = 1'b0; run_to(12);
        check_val("pass_q", hist_q[31:0], 32'hAA);
        check_val("pass_ovr", hist_o[31:0], 32'h0);
        set_cfg(0, 0, 0, 1'b0);
        start_hist();
        for (int i = 0; i < 8; i++) begin
            ps.d[0] = (i % 2 == 0);
            tick();
        end
        ps.d[0] = 1'b0; run_to(12);
        check_val("w0_q", hist_q[31:0], 32'h0);

        // retrigger extends; without retrig the second trigger overruns
        set_cfg(0, 0, 5, 1'b1);
        start_hist(); fire0(); run_to(3); fire0(); run_to(14);
        check_val("retrig_q", hist_q[31:0], 32'h1FE);
        set_cfg(0, 0, 5, 1'b0);
        start_hist(); fire0(); run_to(3); fire0(); run_to(14);
        check_val("noretrig_q", hist_q[31:0], 32'h3E);
        check_val("noretrig_ovr", 32'(hist_o[4:3]), 32'h2);
        clear_ovr();

        // back-to-back acceptance on the cnt==1 cycle
        set_cfg(0, 0, 4, 1'b0);
        start_hist(); fire0(); run_to(4); fire0(); run_to(14);
        check_val("b2b_q", hist_q[31:0], 32'h1FE);
        check_val("b2b_ovr", hist_o[31:0], 32'h0);

        // drop in DELAY, clear, clear coincident with drop
        set_cfg(0, 10, 1, 1'b0);
        start_hist(); fire0(); run_to(5); fire0(); run_to(20);
        ps.ovr_clr[0] = 1'b1; tick(); ps.ovr_clr[0] = 1'b0;
        run_to(25); fire0(); run_to(27); fire0(); tick();
        ps.ovr_clr[0] = 1'b1; fire0(); ps.ovr_clr[0] = 1'b0;
        run_to(40);
        check_val("delay_drop_q", hist_q[31:0], 32'h800);
        check_val("delay_drop_ovr", 32'(hist_o[7:5]), 32'h6);
        check_val("ovr_clr", 32'(hist_o[21:20]), 32'h1);
        check_val("ovr_set_wins", 32'(hist_o[30:28]), 32'h7);
        clear_ovr();

        // reset during ACTIVE
        set_cfg(0, 0, 10, 1'b0);
        start_hist(); fire0(); run_to(3);
        rst = 1'b1; tick(); rst = 1'b0; run_to(8);
        check_val("rst_active_q", 32'(hist_q[4:3]), 32'h1);
        check_val("rst_active_ovr", hist_o[31:0], 32'h0);

        // enable dropped mid-DELAY
        set_cfg(0, 5, 2, 1'b0);
        start_hist(); fire0(); run_to(2);
        ps.en[0] = 1'b0; tick(); ps.en[0] = 1'b1;
        run_to(16);
        check_val("en_drop_q", hist_q[31:0], 32'h0);
        check_val("en_drop_busy", 32'(hist_b[3:2]), 32'h1);

        // random sweep across all channels
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) begin
                for (int c = 0; c < CH; c++)
                    set_cfg(c, vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)],
                            1'($urandom_range(0, 1)));
            end
            for (int c = 0; c < CH; c++) begin
                ps.d[c]       = ($urandom_range(0, 5) == 0);
                ps.en[c]      = ($urandom_range(0, 149) != 0);
                ps.ovr_clr[c] = ($urandom_range(0, 59) == 0);
            end
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0;
        ps.d = '0;
        ps.ovr_clr = '0;
        ps.en = '1;
        repeat (4) tick();
        check_val("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
